// File: rtl/seq_sub_chunked_if.sv
// rtl/seq_sub_chunked_if.sv - operand/result handshake bundle for the chunked subtractor
interface seq_sub_chunked_if #(
    parameter int width = 32
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [width-1:0] A_i;
    logic [width-1:0] B_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [width-1:0] D_o;
    logic             borrow_o;
    logic             zero_o;
    logic             ovf_o;

    modport slave (
        input  in_valid_i,
        input  A_i,
        input  B_i,
        input  out_ready_i,
        output in_ready_o,
        output out_valid_o,
        output D_o,
        output borrow_o,
        output zero_o,
        output ovf_o
    );

    modport master (
        output in_valid_i,
        output A_i,
        output B_i,
        output out_ready_i,
        input  in_ready_o,
        input  out_valid_o,
        input  D_o,
        input  borrow_o,
        input  zero_o,
        input  ovf_o
    );
endinterface

// File: rtl/seq_sub_chunked.sv
// rtl/seq_sub_chunked.sv - multi-cycle D = A - B, one chunk per cycle, LSB chunk first
module seq_sub_chunked #(
    parameter int width = 32,
    parameter int chunk = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    seq_sub_chunked_if.slave   bus
);
    localparam int N  = width / chunk;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic [width-1:0] r_a;
    logic [width-1:0] r_b;
    logic [width-1:0] r_acc;
    logic [width-1:0] r_d_o;
    logic             r_borrow;
    logic             r_zero;
    logic             r_ovf;

    logic [chunk-1:0] w_a_k;
    logic [chunk-1:0] w_b_k;
    logic [chunk:0]   w_sum;
    logic [width-1:0] w_d_full;
    logic             w_accept;
    logic             w_last;

    // Subtraction as A + ~B + carry; carry=1 on entry means "no borrow yet".
    always_comb begin
        w_a_k    = r_a[r_cnt*chunk +: chunk];
        w_b_k    = r_b[r_cnt*chunk +: chunk];
        w_sum    = {1'b0, w_a_k} + {1'b0, ~w_b_k} + {{chunk{1'b0}}, r_carry};
        w_d_full = r_acc;
        w_d_full[r_cnt*chunk +: chunk] = w_sum[chunk-1:0];
    end

    assign w_accept = (r_state == S_IDLE) && bus.in_valid_i && rst_ni;
    assign w_last   = (r_cnt == LAST);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_carry  <= 1'b1;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_d_o    <= '0;
            r_borrow <= 1'b0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a     <= bus.A_i;
                        r_b     <= bus.B_i;
                        r_carry <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc   <= w_d_full;
                    r_carry <= w_sum[chunk];
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_last) begin
                        // Published result only changes here, so D_o holds the previous answer during RUN.
                        r_d_o    <= w_d_full;
                        r_borrow <= ~w_sum[chunk];
                        r_zero   <= (w_d_full == '0);
                        r_ovf    <= (r_a[width-1] != r_b[width-1]) &&
                                    (w_d_full[width-1] != r_a[width-1]);
                        r_cnt    <= '0;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready_i) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready_o  = rst_ni && (r_state == S_IDLE);
    assign bus.out_valid_o = (r_state == S_DONE);
    assign bus.D_o         = r_d_o;
    assign bus.borrow_o    = r_borrow;
    assign bus.zero_o      = r_zero;
    assign bus.ovf_o       = r_ovf;
endmodule

// File: doc/seq_sub_chunked.md
Name: seq_sub_chunked

Overview:
- Multi-cycle unsigned/two's-complement subtractor: D = A - B, the inverse of the combinational adder in the arithmetic library.
- Processes the operands one chunk per cycle, LSB chunk first, with the borrow carried in a register.
- Uses valid/ready handshakes on input and output. Sits in area-constrained datapaths where a full-width single-cycle subtract is too costly.

Parameters:
- width, 32, operand and result word width; must be an integer multiple of chunk.
- chunk, 8, bits processed per cycle; 1 <= chunk <= width.
- N (localparam), width/chunk, number of compute cycles.

Ports:
- clk_i  input  1  clock, rising edge
- rst_ni  input  1  reset, synchronous, active-low
- in_valid_i  input  1  operands valid
- in_ready_o  output  1  block can accept operands
- A_i  input  width  minuend
- B_i  input  width  subtrahend
- out_valid_o  output  1  result valid
- out_ready_i  input  1  consumer accepts result
- D_o  output  width  difference A-B, modulo 2^width
- borrow_o  output  1  unsigned borrow: 1 iff A < B unsigned
- zero_o  output  1  D_o == 0
- ovf_o  output  1  signed overflow of A-B

Behaviour:
- Interface decision: one clock, clk_i; reset rst_ni is synchronous and active-low.
- Sampling: all state updates on the rising edge of clk_i.
- Reset, while rst_ni=0 at an edge:
  - state goes to IDLE;
  - out_valid_o=0;
  - D_o, borrow_o, zero_o, ovf_o = 0;
  - chunk counter = 0.
  - in_ready_o=0 while rst_ni=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready_o=1.
  - On in_valid_i & in_ready_o: latch A_i and B_i, set carry register=1 (no borrow), counter=0, go to RUN.
- RUN:
  - in_ready_o=0 and out_valid_o=0.
  - Each edge computes {c,d} = A[k] + ~B[k] + carry for chunk k = counter (chunk+1 bits).
  - Store d into D chunk k, set carry=c, increment counter.
  - After the edge processing chunk N-1, go to DONE.
- DONE:
  - out_valid_o=1 and in_ready_o=0.
  - D_o and flags are held stable until out_ready_i=1.
  - On out_valid_o & out_ready_i, go to IDLE.
  - Flags and D_o keep their last values after the handshake until the next result.
- Latency: operands accepted at edge t; out_valid_o is high after edge t+N. The minimum period between accepts is N+2 cycles: accept edge, N RUN edges, one DONE handshake edge.
- No overlap: new in_valid_i is ignored (not accepted) outside IDLE. The upstream must hold in_valid_i and the operands until in_ready_o.
- Flags are registered together with the final chunk:
  - borrow_o = ~carry_final;
  - zero_o = (full D == 0);
  - ovf_o = (A[msb] != B[msb]) & (D[msb] != A[msb]).
- out_ready_i may be high before out_valid_o; the handshake completes on the first DONE cycle.
- Reset asserted mid-RUN or in DONE aborts the operation. No result is produced for the aborted operands.
- chunk == width (N=1): single RUN cycle; all rules above still apply.

Test Plan:
- width=32, chunk=8. A=0x00000005, B=0x00000003, out_ready_i=1 → D_o=0x00000002, borrow=0, zero=0, ovf=0; out_valid_o high exactly 4 cycles after the accept edge, for one cycle.
- A=0x00000100, B=0x00000001 → D_o=0x000000FF, borrow propagates across the chunk boundary. A=0x00000003, B=0x00000005 → D_o=0xFFFFFFFE, borrow=1, ovf=0.
- A=0x80000000, B=0x00000001 → D_o=0x7FFFFFFF, borrow=0, ovf=1. A=B=0x12345678 → D_o=0, zero=1, borrow=0.
- Backpressure: out_ready_i=0 for 5 cycles after out_valid_o rises → D_o and flags stable, in_ready_o=0. A new in_valid_i with other operands is not accepted. Raise out_ready_i → handshake, then in_ready_o=1 on the next cycle.
- Reset: pull rst_ni low for one edge during RUN (after 2 chunks) → out_valid_o=0 and D_o=0. After release, in_ready_o=1 and the next operation (A=10, B=4) gives D_o=6 with no stale chunks.
- chunk=32 (N=1): A=0xFFFFFFFF, B=0xFFFFFFFF → D_o=0, zero=1, out_valid_o high 1 cycle after accept. A back-to-back stream of 4 operand pairs is compared against a reference model.
